path_delay_meter: RTL and testbench

Launch/capture controller that sits directly in front of the 100-stage single-path delay chain. It drives the chain's input with a transition and times the resulting edge at the chain's output in clock cycles. It repeats this over a programmable number of trials and reports the sum, minimum and maximum delay. Software compares these figures against a golden-chip fingerprint for delay-based Trojan detection.

---
 rtl/path_meas_pkg.sv | 25 ++
 rtl/path_sync.sv | 26 ++
 rtl/path_delay_meter.sv | 160 ++++++++++++++++
 tb/tb_path_delay_meter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/path_meas_pkg.sv
// Shared types and defaults for the path delay meter.
// Holds the FSM encoding and the effective-timeout helper.
package path_meas_pkg;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_TRIALS_W    = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_GAP_CYC     = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_LAUNCH,
    S_MEASURE,
    S_RECORD
  } state_t;

  // A zero timeout selects the largest count representable in w bits.
  function automatic logic [31:0] eff_timeout(input logic [31:0] t, input int unsigned w);
    logic [31:0] all_ones;
    all_ones = 32'hFFFF_FFFF >> (32 - w);
    return (t == 32'd0) ? all_ones : t;
  endfunction

endpackage

// File: rtl/path_sync.sv
// Multi-flop synchronizer for the asynchronous chain output.
// Latency STAGES cycles; all flops reset to 0.
module path_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/path_delay_meter.sv
// Launches transitions into the delay chain and times their arrival in cycles,
// accumulating sum/min/max over a programmable number of trials.
module path_delay_meter import path_meas_pkg::*; #(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TRIALS_W    = DEF_TRIALS_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int GAP_CYC     = DEF_GAP_CYC
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [TRIALS_W-1:0]       trials,
  input  logic [CNT_W-1:0]          timeout,
  output logic                      path_input,
  input  logic                      path_result,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W+TRIALS_W-1:0] delay_sum,
  output logic [CNT_W-1:0]          delay_min,
  output logic [CNT_W-1:0]          delay_max,
  output logic                      timeout_err
);

  localparam int SUM_W = CNT_W + TRIALS_W;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    tmo_q, tmo_d;
  logic [CNT_W-1:0]    dly_q, dly_d;
  logic [CNT_W-1:0]    min_q, min_d;
  logic [CNT_W-1:0]    max_q, max_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [TRIALS_W-1:0] rem_q, rem_d;
  logic                path_q, path_d;
  logic                base_q, base_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic                sync_out;

  path_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (path_result),
    .q     (sync_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    dly_d   = dly_q;
    min_d   = min_q;
    max_d   = max_q;
    sum_d   = sum_q;
    rem_d   = rem_q;
    path_d  = path_q;
    base_d  = base_q;
    err_d   = err_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sum_d = '0;
          min_d = '1;
          max_d = '0;
          err_d = 1'b0;
          cnt_d = '0;
          if (trials != '0) begin
            rem_d   = trials;
            tmo_d   = CNT_W'(eff_timeout(32'(timeout), CNT_W));
            state_d = S_GAP;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_LAUNCH;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_LAUNCH: begin
        base_d  = sync_out;
        path_d  = ~path_q;
        cnt_d   = '0;
        state_d = S_MEASURE;
      end
      S_MEASURE: begin
        // An arriving edge wins over a timeout reached in the same cycle.
        if (sync_out != base_q) begin
          dly_d   = cnt_q;
          state_d = S_RECORD;
        end else if (cnt_q == tmo_q) begin
          dly_d   = tmo_q;
          err_d   = 1'b1;
          state_d = S_RECORD;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_RECORD: begin
        sum_d = sum_q + SUM_W'(dly_q);
        if (dly_q < min_q) min_d = dly_q;
        if (dly_q > max_q) max_d = dly_q;
        rem_d = rem_q - 1'b1;
        cnt_d = '0;
        if (rem_q == TRIALS_W'(1)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_GAP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
      dly_q   <= '0;
      min_q   <= '1;
      max_q   <= '0;
      sum_q   <= '0;
      rem_q   <= '0;
      path_q  <= 1'b0;
      base_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      dly_q   <= dly_d;
      min_q   <= min_d;
      max_q   <= max_d;
      sum_q   <= sum_d;
      rem_q   <= rem_d;
      path_q  <= path_d;
      base_q  <= base_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign path_input  = path_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign delay_sum   = sum_q;
  assign delay_min   = min_q;
  assign delay_max   = max_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_path_delay_meter.sv
// Randomized bench for path_delay_meter against a delay-arithmetic reference model.
module tb_path_delay_meter;

  localparam int CNT_W    = 16;
  localparam int TRIALS_W = 8;
  localparam int SYNC     = 2;
  localparam int M_LOOP   = 0;
  localparam int M_DLY    = 1;
  localparam int M_STUCK  = 2;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      start = 1'b0;
  logic [TRIALS_W-1:0]       trials = '0;
  logic [CNT_W-1:0]          timeout = '0;
  logic                      path_input;
  logic                      path_result;
  logic                      busy;
  logic                      done;
  logic [CNT_W+TRIALS_W-1:0] delay_sum;
  logic [CNT_W-1:0]          delay_min;
  logic [CNT_W-1:0]          delay_max;
  logic                      timeout_err;

  int total = 0;
  int bad   = 0;

  int        mode = M_LOOP;
  int        dly  = 1;
  logic      inv  = 1'b0;
  logic [63:0] chain_sr = '0;

  always #5 clk = ~clk;

  // Environment: behavioural delay chain, clocked shift register of dly stages.
  always @(posedge clk) chain_sr <= {chain_sr[62:0], path_input};

  assign path_result = (mode == M_LOOP)  ? path_input :
                       (mode == M_STUCK) ? 1'b0 :
                       (chain_sr[6'(dly - 1)] ^ inv);

  path_delay_meter #(
    .CNT_W(CNT_W), .TRIALS_W(TRIALS_W), .SYNC_STAGES(SYNC), .GAP_CYC(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .trials      (trials),
    .timeout     (timeout),
    .path_input  (path_input),
    .path_result (path_result),
    .busy        (busy),
    .done        (done),
    .delay_sum   (delay_sum),
    .delay_min   (delay_min),
    .delay_max   (delay_max),
    .timeout_err (timeout_err)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_path"}, 64'(path_input), 64'd0);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_done"}, 64'(done), 64'd0);
    check_val({tag, "_err"},  64'(timeout_err), 64'd0);
    check_val({tag, "_sum"},  64'(delay_sum), 64'd0);
    check_val({tag, "_min"},  64'(delay_min), 64'hFFFF);
    check_val({tag, "_max"},  64'(delay_max), 64'd0);
  endtask

  // Reference: arrival = chain delay + synchronizer depth, clipped at the timeout.
  task automatic run_case(input int n, input int tmo, input int md, input int dl,
                          input logic iv, input logic repulse, input string tag);
    longint eff, lat, d_exp, budget;
    logic   e_exp, prev, p0, got_done, busy_gap;
    int     toggles;
    mode = md;
    dly  = (dl < 1) ? 1 : dl;
    inv  = iv;
    eff  = (tmo == 0) ? 65535 : tmo;
    lat  = (md == M_STUCK) ? 64'd1 << 40 : (md == M_LOOP) ? SYNC : dl + SYNC;
    d_exp = (lat <= eff) ? lat : eff;
    e_exp = (lat > eff);

    @(negedge clk);
    p0      = path_input;
    start   = 1'b1;
    trials  = TRIALS_W'(n);
    timeout = CNT_W'(tmo);
    @(negedge clk);
    start   = 1'b0;
    trials  = TRIALS_W'($urandom);
    timeout = CNT_W'($urandom);

    if (n == 0) begin
      check_val({tag, "_z_done"}, 64'(done), 64'd1);
      check_val({tag, "_z_busy"}, 64'(busy), 64'd0);
      check_val({tag, "_z_sum"},  64'(delay_sum), 64'd0);
      check_val({tag, "_z_min"},  64'(delay_min), 64'hFFFF);
      check_val({tag, "_z_max"},  64'(delay_max), 64'd0);
      check_val({tag, "_z_err"},  64'(timeout_err), 64'd0);
      toggles = 0;
      prev = path_input;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (path_input != prev) toggles++;
        prev = path_input;
        if (i == 0) check_val({tag, "_z_done_once"}, 64'(done), 64'd0);
      end
      check_val({tag, "_z_toggles"}, 64'(toggles), 64'd0);
      return;
    end

    check_val({tag, "_busy_up"}, 64'(busy), 64'd1);
    budget   = n * (16 + d_exp + 6) + 50;
    toggles  = 0;
    prev     = path_input;
    got_done = 1'b0;
    busy_gap = 1'b0;
    for (longint c = 0; c < budget; c++) begin
      @(negedge clk);
      if (repulse && c == 3) begin
        start = 1'b1; trials = TRIALS_W'(n + 3); timeout = CNT_W'(tmo + 5);
      end
      if (repulse && c == 4) start = 1'b0;
      if (path_input != prev) toggles++;
      prev = path_input;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (!busy) busy_gap = 1'b1;
    end
    start = 1'b0;
    check_val({tag, "_done_seen"}, 64'(got_done), 64'd1);
    check_val({tag, "_busy_hold"}, 64'(busy_gap), 64'd0);
    check_val({tag, "_busy_fall"}, 64'(busy), 64'd0);
    check_val({tag, "_sum"},  64'(delay_sum), 64'(n * d_exp));
    check_val({tag, "_min"},  64'(delay_min), 64'(d_exp));
    check_val({tag, "_max"},  64'(delay_max), 64'(d_exp));
    check_val({tag, "_err"},  64'(timeout_err), 64'(e_exp));
    check_val({tag, "_toggles"}, 64'(toggles), 64'(n));
    check_val({tag, "_path_end"}, 64'(path_input), 64'(p0 ^ n[0]));
    @(negedge clk);
    check_val({tag, "_done_once"}, 64'(done), 64'd0);
    check_val({tag, "_sum_hold"}, 64'(delay_sum), 64'(n * d_exp));
  endtask

  task automatic reset_mid_run();
    int   toggles;
    logic prev, seen_done;
    mode = M_LOOP;
    @(negedge clk);
    start = 1'b1; trials = TRIALS_W'(3); timeout = CNT_W'(100);
    @(negedge clk);
    start = 1'b0;
    toggles = 0;
    prev = path_input;
    for (int c = 0; c < 200 && toggles < 2; c++) begin
      @(negedge clk);
      if (path_input != prev) toggles++;
      prev = path_input;
    end
    check_val("rst_reach_trial2", 64'(toggles), 64'd2);
    @(negedge clk);
    check_val("rst_partial_sum", 64'(delay_sum), 64'd2);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    seen_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check_val("rst_no_done", 64'(seen_done), 64'd0);
    run_case(1, 100, M_LOOP, 0, 1'b0, 1'b0, "rst_after");
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, md, dl, tmo;
    logic iv;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_case(4, 100, M_LOOP, 0, 1'b0, 1'b0, "loop4");
    run_case(3, 100, M_DLY,  7, 1'b0, 1'b0, "dly7");
    run_case(3, 100, M_DLY,  7, 1'b1, 1'b0, "dly7_inv");
    run_case(2, 20,  M_STUCK, 0, 1'b0, 1'b0, "stuck");
    run_case(0, 50,  M_LOOP, 0, 1'b0, 1'b0, "zero");
    run_case(3, 50,  M_DLY,  4, 1'b0, 1'b1, "repulse");
    run_case(2, 0,   M_DLY,  3, 1'b1, 1'b0, "tmo0");
    run_case(2, 9,   M_DLY,  7, 1'b0, 1'b0, "tmo_edge");
    run_case(2, 8,   M_DLY,  7, 1'b0, 1'b0, "tmo_short");
    reset_mid_run();

    for (int r = 0; r < 12; r++) begin
      n  = $urandom_range(1, 5);
      md = ($urandom_range(0, 5) == 0) ? M_STUCK : ($urandom_range(0, 3) == 0 ? M_LOOP : M_DLY);
      dl = $urandom_range(1, 12);
      iv = 1'($urandom_range(0, 1));
      tmo = $urandom_range(0, 30);
      if (md == M_STUCK && tmo == 0) tmo = 25;
      run_case(n, tmo, md, dl, iv, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
